ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RV32IM five-stage pipeline, between the ID/EX boundary and `MEM_stage`. It resolves operand forwarding, runs single-cycle ALU and multiply operations, and runs an iterative 32-step divider for DIV/DIVU/REM/REMU. It registers its results into the EX/MEM bus. While a division runs it stalls the front end and drives bubbles to MEM.

## Interface
Parameters:
- `DIV_STEPS`, default 32: radix-2 iterations per division; fixed to XLEN.

Ports:
- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `bus_in`  in  `ID2EX_if` (`id_ex_data_t`): decoded instruction.
  - Fields: `pc`, `rs1_data`, `rs2_data`, `imm`, `rd_addr`, `ALUOp`, `ALUSrcA`, `ALUSrcB`, `MemWrite`, `MemRead`, `RegWrite`, `WBSel`.
- `bus_out`  out  `EX2MEM_if` (`ex_mem_data_t`): registered `alu_result`, `rd_data2`, `rd_addr`, `MemWrite`, `MemRead`, `RegWrite`, `WBSel`.
- `fwd_a_sel`, `fwd_b_sel`  in  2 (`fwd_sel_e`) each: operand source selection.
  - `FWD_NONE`: ID/EX value.
  - `FWD_MEM`: `mem_fwd_data`.
  - `FWD_WB`: `wb_fwd_data`.
- `mem_fwd_data`  in  32: forwarded EX/MEM `alu_result`.
- `wb_fwd_data`  in  32: forwarded writeback value.
- `flush_i`  in  1: kill the current EX instruction (branch mispredict/redirect).
- `stall_o`  out  1: combinational; holds PC, IF/ID and ID/EX while high.

## Operation
- Operand A: `ALUSrcA` selects the forwarded rs1 or `pc`.
- Operand B: `ALUSrcB` selects the forwarded rs2 or `imm`.
- `rd_data2` is always the forwarded rs2, so stores get forwarded data.
- Base ALU ops (ADD…SRA, SLT/SLTU, LUI pass-through) and MUL/MULH/MULHSU/MULHU complete in one cycle.
  - Shift amount is B[4:0].
  - MULH variants take the upper 32 bits of the 64-bit signed/unsigned product.
- Divider FSM has states IDLE and BUSY.
  - IDLE → BUSY: on an edge with a divide op presented, not special, and `!flush_i`. Latch operand magnitudes, the signs, the op and count=`DIV_STEPS`.
  - BUSY: each edge performs one restoring step and decrements count.
  - BUSY → IDLE: on the edge where count==1, after the final step. The signed result is corrected and written to `bus_out`.
- Special divides complete in one cycle with no stall and no BUSY entry:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed overflow 0x80000000 / -1: quotient 0x80000000, remainder 0.
- Signs:
  - Quotient is negative iff the operand signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Control fields are taken from `bus_in` on the completing edge; upstream holds it stable throughout the stall.
- `flush_i`: the next `bus_out` is a bubble (all fields 0). If BUSY, abort and return to IDLE; `stall_o` drops the same cycle.
- `rst`: FSM to IDLE, count 0, `bus_out` all-zero (bubble), `stall_o` 0.
- A reset mid-division discards it; no partial result is written.

## Timing
- Non-divide latency: 1 cycle; the result is on `bus_out` after the edge that samples `bus_in`.
- Division presented in cycle 0:
  - `stall_o`=1 in cycles 0..31 and 0 in cycle 32.
  - The result appears on `bus_out` after the edge ending cycle 32, i.e. 33 cycles of latency and 32 stall cycles.
- `bus_out` is a bubble (RegWrite/MemRead/MemWrite=0, all fields 0) after every edge while BUSY, except the completing edge.
- `stall_o` = (IDLE & non-special divide & !flush_i) | (BUSY & count>1 & !flush_i).
- Flush and division start in the same cycle: flush wins; no BUSY entry, bubble out.
- Back-to-back divides: the second is sampled in the cycle after completion and starts a new 33-cycle sequence.

## Structure
- `core_pkg` additions:
  - `alu_op_e` extended with MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - `fwd_sel_e`.
  - `id_ex_data_t`.
  - `XLEN`=32.
- New interface `ID2EX_if` mirroring `EX2MEM_if`.
- One sub-module, `div_unit`: owns the FSM, counter, sign handling and special-case detection.
  - Ports: clk, rst, start, flush, op, a, b, busy, done, result.
- `ex_stage` keeps the forwarding muxes, the ALU, the multiplier and the output register.

## Test plan
- **ADD, forwarded operand:** ADD with `fwd_a_sel`=FWD_MEM, `mem_fwd_data`=0x10, rs2=0x22 → after 1 edge `alu_result`=0x32, `rd_addr` and RegWrite passed through, `stall_o` never high.
- **MULHU, then MULH:** MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE in 1 cycle. MULH of the same operands → 0x00000000.
- **DIVU:** DIVU 100/7 → `stall_o` high exactly 32 cycles, bubbles for 32 edges, then `alu_result`=14. REMU 100/7 → 2 with the same timing.
- **Signed divide/remainder:** DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF.
- **Special cases:** DIV 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000. All in 1 cycle, `stall_o`=0.
- **Abort mid-division:** assert `flush_i` at BUSY cycle 10 → next `bus_out` bubble, `stall_o` 0 the same cycle, FSM IDLE; a following ADD completes in 1 cycle. Repeat with `rst` instead of `flush_i` → same bubble and IDLE.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the RV32IM pipeline: ALU opcodes, forwarding selects,
// the ID/EX and EX/MEM pipeline records and the divider state encoding.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_LUI,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd_addr;
        alu_op_e         ALUOp;
        logic            ALUSrcA;   // 0: rs1, 1: pc
        logic            ALUSrcB;   // 0: rs2, 1: imm
        logic            MemWrite;
        logic            MemRead;
        logic            RegWrite;
        logic [1:0]      WBSel;
    } id_ex_data_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rd_data2;
        logic [4:0]      rd_addr;
        logic            MemWrite;
        logic            MemRead;
        logic            RegWrite;
        logic [1:0]      WBSel;
    } ex_mem_data_t;

    // True for the four ops that go through the iterative divider.
    function automatic logic is_div_op(alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_if.sv
// Pipeline boundary bundles around the execute stage. Each wraps one packed
// record so stages can be wired through a single interface instance.
interface ID2EX_if;
    core_pkg::id_ex_data_t data;
    modport producer (output data);
    modport consumer (input  data);
endinterface

interface EX2MEM_if;
    core_pkg::ex_mem_data_t data;
    modport producer (output data);
    modport consumer (input  data);
endinterface

// File: rtl/ex_stage_div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU. Works on magnitudes and
// fixes the signs on the completing edge; divide-by-zero and signed overflow
// are resolved combinationally without entering BUSY.
module div_unit
    import core_pkg::*;
#(
    parameter int DIV_STEPS = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(DIV_STEPS + 1);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
    logic            is_rem_q, neg_quo_q, neg_rem_q;

    // Operand classification for the op presented this cycle
    logic            is_signed, is_rem, div_zero, signed_ovf, special;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    // One restoring step on the latched state
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] rem_step, quo_step, quo_fin, rem_fin;

    // Decode the incoming op, detect special cases and form magnitudes
    always_comb begin
        is_signed  = (op == ALU_DIV) || (op == ALU_REM);
        is_rem     = (op == ALU_REM) || (op == ALU_REMU);
        div_zero   = (b == '0);
        signed_ovf = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special    = div_zero || signed_ovf;
        neg_a      = is_signed && a[XLEN-1];
        neg_b      = is_signed && b[XLEN-1];
        mag_a      = neg_a ? (XLEN'(0) - a) : a;
        mag_b      = neg_b ? (XLEN'(0) - b) : b;
        if (div_zero) begin
            special_res = is_rem ? a : '1;
        end else begin
            special_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Shift in the next dividend bit and subtract the divisor if it fits
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, dvsr_q};
        rem_step = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_step = {quo_q[XLEN-2:0], ~diff[XLEN]};
        quo_fin  = neg_quo_q ? (XLEN'(0) - quo_step) : quo_step;
        rem_fin  = neg_rem_q ? (XLEN'(0) - rem_step) : rem_step;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a flush always wins over starting or continuing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (start && !special && !flush) state_d = DIV_BUSY;
            DIV_BUSY: if (flush || count_q == CW'(1))  state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // FSM outputs: stall request, completion strobe and the result to capture
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        result = special_res;
        if (state_q == DIV_IDLE) begin
            busy = start && !special && !flush;
            done = start && special;
        end else begin
            busy   = (count_q > CW'(1)) && !flush;
            done   = (count_q == CW'(1));
            result = is_rem_q ? rem_fin : quo_fin;
        end
    end

    // Datapath: latch magnitudes and signs on entry, then iterate
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (state_q == DIV_IDLE) begin
            if (state_d == DIV_BUSY) begin
                count_q   <= CW'(DIV_STEPS);
                rem_q     <= '0;
                quo_q     <= mag_a;
                dvsr_q    <= mag_b;
                is_rem_q  <= is_rem;
                neg_quo_q <= neg_a ^ neg_b;
                neg_rem_q <= neg_a;
            end
        end else begin
            rem_q   <= rem_step;
            quo_q   <= quo_step;
            count_q <= (state_d == DIV_IDLE) ? '0 : (count_q - CW'(1));
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and multiplier,
// iterative divider, and the registered EX/MEM output record.
module ex_stage
    import core_pkg::*;
#(
    parameter int DIV_STEPS = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  id_ex_data_t     bus_in,
    output ex_mem_data_t    bus_out,
    input  fwd_sel_e        fwd_a_sel,
    input  fwd_sel_e        fwd_b_sel,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush_i,
    output logic            stall_o
);

    logic [XLEN-1:0] fwd_src [2];
    fwd_sel_e        fwd_sel [2];
    logic [XLEN-1:0] fwd_val [2];

    logic [XLEN-1:0] op_a, op_b, alu_res;
    logic [63:0]     mul_a, mul_b, prod;
    logic            is_div, div_busy, div_done;
    logic [XLEN-1:0] div_res;
    ex_mem_data_t    bus_q, bus_d;

    assign fwd_src[0] = bus_in.rs1_data;
    assign fwd_src[1] = bus_in.rs2_data;
    assign fwd_sel[0] = fwd_a_sel;
    assign fwd_sel[1] = fwd_b_sel;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            // Pick the register value or a bypass from MEM/WB for rs1 and rs2
            always_comb begin
                unique case (fwd_sel[gi])
                    FWD_MEM: fwd_val[gi] = mem_fwd_data;
                    FWD_WB:  fwd_val[gi] = wb_fwd_data;
                    default: fwd_val[gi] = fwd_src[gi];
                endcase
            end
        end
    endgenerate

    assign op_a   = bus_in.ALUSrcA ? bus_in.pc  : fwd_val[0];
    assign op_b   = bus_in.ALUSrcB ? bus_in.imm : fwd_val[1];
    assign is_div = is_div_op(bus_in.ALUOp);

    // One 64-bit multiplier; sign-extension of each operand selects the MULH flavour
    always_comb begin
        mul_a = {{32{op_a[XLEN-1] && (bus_in.ALUOp == ALU_MULH || bus_in.ALUOp == ALU_MULHSU)}}, op_a};
        mul_b = {{32{op_b[XLEN-1] && (bus_in.ALUOp == ALU_MULH)}}, op_b};
        prod  = mul_a * mul_b;
    end

    // Single-cycle ALU and multiply results
    always_comb begin
        alu_res = '0;
        case (bus_in.ALUOp)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_SLL:    alu_res = op_a << op_b[4:0];
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SRL:    alu_res = op_a >> op_b[4:0];
            ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_OR:     alu_res = op_a | op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_LUI:    alu_res = op_b;
            ALU_MUL:    alu_res = prod[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_res = prod[63:32];
            default:    alu_res = '0;
        endcase
    end

    div_unit #(
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (is_div),
        .flush  (flush_i),
        .op     (bus_in.ALUOp),
        .a      (op_a),
        .b      (op_b),
        .busy   (div_busy),
        .done   (div_done),
        .result (div_res)
    );

    assign stall_o = div_busy;

    // Next EX/MEM record: bubble on flush or while a division is still iterating
    always_comb begin
        bus_d = '0;
        if (!flush_i && (!is_div || div_done)) begin
            bus_d.alu_result = is_div ? div_res : alu_res;
            bus_d.rd_data2   = fwd_val[1];
            bus_d.rd_addr    = bus_in.rd_addr;
            bus_d.MemWrite   = bus_in.MemWrite;
            bus_d.MemRead    = bus_in.MemRead;
            bus_d.RegWrite   = bus_in.RegWrite;
            bus_d.WBSel      = bus_in.WBSel;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q <= '0;
        end else begin
            bus_q <= bus_d;
        end
    end

    assign bus_out = bus_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed table, hand-written abort sequences and
// randomized ops checked against a plain-arithmetic reference model.
module tb_ex_stage;
    import core_pkg::*;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    fwd_sel_e fwd_a_sel = FWD_NONE;
    fwd_sel_e fwd_b_sel = FWD_NONE;
    logic [31:0] mem_fwd_data = '0;
    logic [31:0] wb_fwd_data  = '0;
    logic     flush_i = 1'b0;
    logic     stall_o;

    ID2EX_if  id2ex ();
    EX2MEM_if ex2mem ();

    ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .bus_in       (id2ex.data),
        .bus_out      (ex2mem.data),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_data  (wb_fwd_data),
        .flush_i      (flush_i),
        .stall_o      (stall_o)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    logic [9:0]  exp_ctrl;
    logic [31:0] exp_a, exp_b, exp_d2;

    typedef struct {
        alu_op_e     op;
        logic [31:0] pc, rs1, rs2, imm;
        logic        sa, sb;
        fwd_sel_e    fa, fb;
        logic [31:0] mem, wb;
        logic [31:0] exp;
        int          stalls;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fwd(fwd_sel_e s, logic [31:0] r, logic [31:0] m, logic [31:0] w);
        if (s == FWD_MEM) return m;
        if (s == FWD_WB)  return w;
        return r;
    endfunction

    // Reference: RISC-V M/I semantics written with 64-bit integer arithmetic
    function automatic logic [31:0] model(alu_op_e op, logic [31:0] a, logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     r;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (op)
            ALU_ADD:    begin p = ua + ub; r = p[31:0]; end
            ALU_SUB:    begin p = ua - ub; r = p[31:0]; end
            ALU_SLL:    begin p = ua << b[4:0]; r = p[31:0]; end
            ALU_SLT:    r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:   r = (ua < ub) ? 32'd1 : 32'd0;
            ALU_XOR:    r = a ^ b;
            ALU_SRL:    begin p = ua >> b[4:0]; r = p[31:0]; end
            ALU_SRA:    begin p = sa >>> b[4:0]; r = p[31:0]; end
            ALU_OR:     r = a | b;
            ALU_AND:    r = a & b;
            ALU_LUI:    r = b;
            ALU_MUL:    begin p = sa * sb; r = p[31:0]; end
            ALU_MULH:   begin p = sa * sb; r = p[63:32]; end
            ALU_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; r = p[63:32]; end
            ALU_DIV:    if (b == 0) r = 32'hFFFF_FFFF; else if (ovf) r = 32'h8000_0000;
                        else begin p = sa / sb; r = p[31:0]; end
            ALU_REM:    if (b == 0) r = a; else if (ovf) r = 32'h0;
                        else begin p = sa % sb; r = p[31:0]; end
            ALU_DIVU:   if (b == 0) r = 32'hFFFF_FFFF; else begin p = ua / ub; r = p[31:0]; end
            ALU_REMU:   if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; end
            default:    r = '0;
        endcase
        return r;
    endfunction

    function automatic int model_stalls(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic sgn;
        sgn = (op == ALU_DIV) || (op == ALU_REM);
        if (!is_div_op(op) || b == 0) return 0;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Present one instruction; also records the expected operands and pass-through fields
    task automatic drive(vec_t v, logic [4:0] rd, logic [4:0] ctl);
        id2ex.data.pc       = v.pc;
        id2ex.data.rs1_data = v.rs1;
        id2ex.data.rs2_data = v.rs2;
        id2ex.data.imm      = v.imm;
        id2ex.data.rd_addr  = rd;
        id2ex.data.ALUOp    = v.op;
        id2ex.data.ALUSrcA  = v.sa;
        id2ex.data.ALUSrcB  = v.sb;
        id2ex.data.MemWrite = ctl[4];
        id2ex.data.MemRead  = ctl[3];
        id2ex.data.RegWrite = ctl[2];
        id2ex.data.WBSel    = ctl[1:0];
        fwd_a_sel    = v.fa;
        fwd_b_sel    = v.fb;
        mem_fwd_data = v.mem;
        wb_fwd_data  = v.wb;
        exp_ctrl = {rd, ctl};
        exp_a    = v.sa ? v.pc  : fwd(v.fa, v.rs1, v.mem, v.wb);
        exp_d2   = fwd(v.fb, v.rs2, v.mem, v.wb);
        exp_b    = v.sb ? v.imm : exp_d2;
    endtask

    // Count stall cycles, check bubbles while stalled, then check the completed record
    task automatic run(string name, logic [31:0] exp_res, int exp_stalls);
        int stalls;
        bit bub_ok;
        stalls = 0;
        bub_ok = 1'b1;
        #1;
        while (stall_o && stalls < 64) begin
            @(posedge clk); #1;
            stalls++;
            if (ex2mem.data !== '0) bub_ok = 1'b0;
        end
        chk({name, "_stalls"}, 128'(stalls), 128'(exp_stalls));
        if (exp_stalls > 0) chk({name, "_bubbles"}, 128'(bub_ok), 128'(1));
        @(posedge clk); #1;
        chk({name, "_result"}, 128'(ex2mem.data.alu_result), 128'(exp_res));
        chk({name, "_rd_data2"}, 128'(ex2mem.data.rd_data2), 128'(exp_d2));
        chk({name, "_ctrl"},
            128'({ex2mem.data.rd_addr, ex2mem.data.MemWrite, ex2mem.data.MemRead,
                  ex2mem.data.RegWrite, ex2mem.data.WBSel}), 128'(exp_ctrl));
        $display("txn %s res=%08h stalls=%0d", name, ex2mem.data.alu_result, stalls);
    endtask

    function automatic vec_t mk(alu_op_e op, logic [31:0] a, logic [31:0] b, logic [31:0] exp, int st);
        vec_t v;
        v = '{op, 32'h0000_0400, a, b, 32'h0, 1'b0, 1'b0, FWD_NONE, FWD_NONE, 32'h0, 32'h0, exp, st};
        return v;
    endfunction

    initial begin
        vec_t v;
        int   ntbl;
        id2ex.data = '0;

        tbl[0]  = '{ALU_ADD, 32'h0, 32'hDEAD, 32'h22, 32'h0, 1'b0, 1'b0, FWD_MEM, FWD_NONE,
                    32'h10, 32'h0, 32'h32, 0};
        tbl[1]  = mk(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        tbl[2]  = mk(ALU_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0);
        tbl[3]  = mk(ALU_DIVU,  32'd100, 32'd7, 32'd14, 32);
        tbl[4]  = mk(ALU_REMU,  32'd100, 32'd7, 32'd2, 32);
        tbl[5]  = mk(ALU_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        tbl[6]  = mk(ALU_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        tbl[7]  = mk(ALU_DIV,   32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        tbl[8]  = mk(ALU_REM,   32'd5, 32'd0, 32'd5, 0);
        tbl[9]  = mk(ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        tbl[10] = mk(ALU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
        tbl[11] = '{ALU_SUB, 32'h0, 32'd10, 32'h55, 32'd3, 1'b0, 1'b1, FWD_NONE, FWD_NONE,
                    32'h0, 32'h0, 32'd7, 0};
        tbl[12] = '{ALU_ADD, 32'h1000, 32'h77, 32'h99, 32'h0, 1'b1, 1'b0, FWD_NONE, FWD_WB,
                    32'h0, 32'h24, 32'h1024, 0};
        tbl[13] = mk(ALU_SRA,   32'h8000_0000, 32'h24, 32'hF800_0000, 0);
        tbl[14] = mk(ALU_SLT,   32'hFFFF_FFFF, 32'd1, 32'd1, 0);
        tbl[15] = mk(ALU_SLTU,  32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        tbl[16] = '{ALU_LUI, 32'h0, 32'h1, 32'h2, 32'h1234_5000, 1'b0, 1'b1, FWD_NONE, FWD_NONE,
                    32'h0, 32'h0, 32'h1234_5000, 0};
        tbl[17] = mk(ALU_REMU,  32'd9, 32'd0, 32'd9, 0);
        tbl[18] = mk(ALU_DIVU,  32'd7, 32'hFFFF_FFFF, 32'd0, 32);
        tbl[19] = mk(ALU_MUL,   32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 0);
        ntbl = 20;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_bus_out", 128'(ex2mem.data), 128'(0));
        chk("reset_stall", 128'(stall_o), 128'(0));

        // Directed table; divides 3 and 4 run back to back
        for (int i = 0; i < ntbl; i++) begin
            drive(tbl[i], 5'(i + 1), 5'b00101);
            run($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].stalls);
        end

        // Flush on a plain ADD gives a bubble
        drive(tbl[0], 5'd3, 5'b00101);
        flush_i = 1'b1;
        #1;
        chk("flush_add_stall", 128'(stall_o), 128'(0));
        @(posedge clk); #1;
        chk("flush_add_bubble", 128'(ex2mem.data), 128'(0));
        flush_i = 1'b0;

        // Flush in the same cycle a division is presented: no stall, no BUSY
        drive(tbl[3], 5'd4, 5'b00101);
        flush_i = 1'b1;
        #1;
        chk("flush_start_stall", 128'(stall_o), 128'(0));
        @(posedge clk); #1;
        chk("flush_start_bubble", 128'(ex2mem.data), 128'(0));
        flush_i = 1'b0;
        drive(tbl[0], 5'd5, 5'b00101);
        run("after_flush_start", 32'h32, 0);

        // Abort with flush in BUSY cycle 10
        drive(tbl[3], 5'd6, 5'b00101);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_pre_stall", 128'(stall_o), 128'(1));
        flush_i = 1'b1;
        #1;
        chk("abort_flush_stall", 128'(stall_o), 128'(0));
        @(posedge clk); #1;
        chk("abort_flush_bubble", 128'(ex2mem.data), 128'(0));
        flush_i = 1'b0;
        drive(tbl[0], 5'd7, 5'b00101);
        run("after_abort_flush", 32'h32, 0);
        drive(tbl[4], 5'd8, 5'b00101);
        run("div_after_abort", 32'd2, 32);

        // Abort with reset in BUSY cycle 10
        drive(tbl[5], 5'd9, 5'b00101);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_rst_bubble", 128'(ex2mem.data), 128'(0));
        rst = 1'b0;
        drive(tbl[0], 5'd10, 5'b00101);
        run("after_abort_rst", 32'h32, 0);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            int k;
            v.op  = alu_op_e'(5'($urandom_range(0, 18)));
            v.pc  = $urandom; v.rs1 = $urandom; v.rs2 = $urandom; v.imm = $urandom;
            v.mem = $urandom; v.wb  = $urandom;
            v.sa  = 1'($urandom_range(0, 1));
            v.sb  = 1'($urandom_range(0, 1));
            v.fa  = fwd_sel_e'(2'($urandom_range(0, 2)));
            v.fb  = fwd_sel_e'(2'($urandom_range(0, 2)));
            k = $urandom_range(0, 7);
            if (k == 0) begin
                v.rs2 = 0; v.mem = 0; v.wb = 0; v.imm = 0;
            end else if (k == 1) begin
                v.rs1 = 32'h8000_0000; v.pc = 32'h8000_0000;
                v.rs2 = '1; v.imm = '1;
                v.mem = (v.fa != FWD_NONE && !v.sa) ? 32'h8000_0000 : '1;
                v.wb  = v.mem;
            end else if (k == 2) begin
                v.rs2 = $urandom_range(0, 300); v.imm = v.rs2;
                v.mem = v.rs2; v.wb = v.rs2;
            end
            v.exp    = 0;
            v.stalls = 0;
            drive(v, 5'($urandom), 5'($urandom));
            run($sformatf("rnd%0d_%s", n, v.op.name()), model(v.op, exp_a, exp_b),
                model_stalls(v.op, exp_a, exp_b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
